axi_lite_ram_responder: RTL and testbench

- AXI4-Lite subordinate (responder) backed by an on-chip word RAM with byte-lane write enables.
- It is the far end of the bus driven by the core's AXI controller: it accepts AW/W/AR transactions and returns B/R responses.
- Serves as the instruction/data memory for simulation and FPGA builds.
- One outstanding read and one outstanding write at a time; the read and write paths run independently and concurrently.

---
 rtl/axi_pkg.sv | 14 +
 rtl/common_types_pkg.sv | 6 +
 rtl/byte_en_ram.sv | 32 +++
 rtl/axi_lite_ram_responder.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_ram_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// AXI4-Lite response codes and data-path types shared by bus endpoints.
package axi_pkg;

   typedef common_types_pkg::word_t word_t;
   typedef logic [3:0] strb_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

endpackage

// File: rtl/common_types_pkg.sv
// Shared scalar types used across the SoC codebase.
package common_types_pkg;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/byte_en_ram.sv
// Word RAM with one synchronous read port and one byte-lane-masked write port.
// A same-edge read and write to one word return the old contents.
module byte_en_ram
   import axi_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             re,
   input  logic [IDX_W-1:0] raddr,
   output word_t            rdata,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  word_t            wdata,
   input  strb_t            wstrb
);

   // NOTE: the array and its read register have no reset; RAM macros cannot be
   // cleared, and the responder masks rdata until a valid read has landed.
   word_t mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_lite_ram_responder.sv
// AXI4-Lite subordinate in front of byte_en_ram: independent single-outstanding
// read and write FSMs, AW/W holding registers and the address window decode.
module axi_lite_ram_responder
   import axi_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  word_t                 wdata,
   input  strb_t                 wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output word_t                 rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic { W_IDLE, W_RESP } wr_state_t;
   typedef enum logic { R_IDLE, R_RESP } rd_state_t;

   // The extra top bit catches addresses below BASE_ADDR as a borrow.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH:0] off;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      return (off >> (IDX_W + 2)) == '0;
   endfunction

   function automatic idx_t to_idx(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      return idx_t'(off >> 2);
   endfunction

   wr_state_t             wr_state_q, wr_state_d;
   logic                  awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   axi_resp_t             bresp_q, bresp_d;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   word_t                 w_data_q, w_data_d;
   strb_t                 w_strb_q, w_strb_d;

   rd_state_t             rd_state_q, rd_state_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d;
   logic                  rd_ok_q, rd_ok_d;
   axi_resp_t             rresp_q, rresp_d;

   logic                  aw_hs, w_hs, ar_hs, ram_we, ram_re, wr_hit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   word_t                 wr_data, ram_q;
   strb_t                 wr_strb;

   assign aw_hs   = awvalid & awready_q;
   assign w_hs    = wvalid & wready_q;
   assign ar_hs   = arvalid & arready_q;
   // Bypass the holding registers so a same-cycle handshake commits at once.
   assign wr_addr = aw_held_q ? aw_addr_q : awaddr;
   assign wr_data = w_held_q ? w_data_q : wdata;
   assign wr_strb = w_held_q ? w_strb_q : wstrb;
   assign wr_hit  = in_range(wr_addr);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      wr_state_d = wr_state_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      ram_we     = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
               ram_we     = wr_hit;
               bvalid_d   = 1'b1;
               bresp_d    = wr_hit ? OKAY : SLVERR;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = W_RESP;
            end else begin
               if (aw_hs) begin
                  aw_held_d = 1'b1;
                  aw_addr_d = awaddr;
               end
               if (w_hs) begin
                  w_held_d = 1'b1;
                  w_data_d = wdata;
                  w_strb_d = wstrb;
               end
               awready_d = !(aw_held_q | aw_hs);
               wready_d  = !(w_held_q | w_hs);
            end
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rd_ok_d    = rd_ok_q;
      rresp_d    = rresp_q;
      ram_re     = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               ram_re     = 1'b1;
               arready_d  = 1'b0;
               rvalid_d   = 1'b1;
               rd_ok_d    = in_range(araddr);
               rresp_d    = in_range(araddr) ? OKAY : SLVERR;
               rd_state_d = R_RESP;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_RESP: begin
            if (rready) begin
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         wr_state_q <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rd_ok_q    <= 1'b0;
         rresp_q    <= OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rd_ok_q    <= rd_ok_d;
         rresp_q    <= rresp_d;
      end
   end

   byte_en_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk   (clk),
      .re    (ram_re),
      .raddr (to_idx(araddr)),
      .rdata (ram_q),
      .we    (ram_we),
      .waddr (to_idx(wr_addr)),
      .wdata (wr_data),
      .wstrb (wr_strb)
   );

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   // Zero until a read lands, and for out-of-range reads.
   assign rdata   = rd_ok_q ? ram_q : '0;

endmodule

// File: tb/tb_axi_lite_ram_responder.sv
// Self-checking bench for axi_lite_ram_responder: directed scenarios plus
// randomized traffic against a word-array reference model.
module tb_axi_lite_ram_responder;
   import axi_pkg::*;

   localparam int DEPTH = 1024;
   localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   word_t       wdata;
   strb_t       wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   word_t       rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   axi_lite_ram_responder dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // Reference model: base address 0, word index = addr / 4.
   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return (a < LIMIT) ? 2'b00 : 2'b10;
   endfunction

   function automatic void model_write(input logic [31:0] a, input word_t d, input strb_t s);
      logic [31:0] w;
      if (a >= LIMIT) return;
      w = mdl.exists(int'(a / 4)) ? mdl[int'(a / 4)] : 32'hxxxx_xxxx;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[int'(a / 4)] = w;
   endfunction

   function automatic word_t model_read(input logic [31:0] a);
      if (a >= LIMIT) return 32'h0;
      return mdl[int'(a / 4)];
   endfunction

   // Bus drivers: called on a negedge, return on the negedge after the handshake.
   task automatic send_aw(input logic [31:0] a, input int dly, output bit to);
      to = 1'b0;
      repeat (dly) @(negedge clk);
      awaddr = a; awvalid = 1'b1;
      for (int k = 0; !awready; k++) begin
         if (k >= 50) begin to = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic send_w(input word_t d, input strb_t s, input int dly, output bit to);
      to = 1'b0;
      repeat (dly) @(negedge clk);
      wdata = d; wstrb = s; wvalid = 1'b1;
      for (int k = 0; !wready; k++) begin
         if (k >= 50) begin to = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output bit to);
      to = 1'b0;
      araddr = a; arvalid = 1'b1;
      for (int k = 0; !arready; k++) begin
         if (k >= 50) begin to = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   // With bready=1: returns B fields seen right after the later handshake and
   // whether the channel looked idle again one cycle later.
   task automatic do_write(input logic [31:0] a, input word_t d, input strb_t s,
                           input int aw_dly, input int w_dly,
                           output logic [2:0] b_seen, output logic retired, output bit to);
      bit t1, t2;
      fork
         send_aw(a, aw_dly, t1);
         send_w(d, s, w_dly, t2);
      join
      to = t1 | t2;
      b_seen = {bvalid, bresp};
      @(negedge clk);
      retired = !bvalid && awready && wready;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [34:0] r_seen, output bit to);
      send_ar(a, to);
      r_seen = {rvalid, rresp, rdata};
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h, want all zero",
                  awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
      rst = 1'b0;
      n_checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         n_fail++;
         $display("FAIL ready_before_edge: got %b want 000", {awready, wready, arready});
      end
      @(negedge clk);
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_fail++;
         $display("FAIL ready_after_edge: got %b want 111", {awready, wready, arready});
      end
   endtask

   task automatic test_basic;
      logic [2:0] b; logic ret; logic [34:0] r; bit to;
      n_checks++;
      if (bvalid !== 1'b0) begin n_fail++; $display("FAIL basic_bvalid_idle: got %b want 0", bvalid); end
      do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, b, ret, to);
      model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
      n_checks++;
      if (to || b !== {1'b1, exp_resp(32'h10)} || !ret) begin
         n_fail++; $display("FAIL basic_write: got to=%b b=%b ret=%b want to=0 b=100 ret=1", to, b, ret);
      end
      do_read(32'h10, r, to);
      n_checks++;
      if (to || r !== {1'b1, 2'b00, model_read(32'h10)}) begin
         n_fail++; $display("FAIL basic_read: got to=%b %h want %h", to, r, {1'b1, 2'b00, model_read(32'h10)});
      end
   endtask

   task automatic test_w_before_aw;
      logic [34:0] r; bit to;
      wdata = 32'h0000_00AA; wstrb = 4'b0001; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({wready, awready, bvalid} !== 3'b010) begin
            n_fail++; $display("FAIL w_held_wait%0d: got wready,awready,bvalid=%b want 010", i, {wready, awready, bvalid});
         end
         if (i < 2) @(negedge clk);
      end
      awaddr = 32'h10; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      model_write(32'h10, 32'h0000_00AA, 4'b0001);
      n_checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
         n_fail++; $display("FAIL w_first_b: got %b want 10000", {bvalid, bresp, awready, wready});
      end
      @(negedge clk);
      n_checks++;
      if ({bvalid, awready, wready} !== 3'b011) begin
         n_fail++; $display("FAIL w_first_retire: got %b want 011", {bvalid, awready, wready});
      end
      do_read(32'h10, r, to);
      n_checks++;
      if (to || r !== {1'b1, 2'b00, model_read(32'h10)}) begin
         n_fail++; $display("FAIL w_first_read: got %h want %h", r, {1'b1, 2'b00, model_read(32'h10)});
      end
   endtask

   task automatic test_boundaries;
      logic [2:0] b; logic ret; logic [34:0] r; bit to;
      do_write(32'h0, 32'h0BAD_F00D, 4'hF, 0, 1, b, ret, to);
      model_write(32'h0, 32'h0BAD_F00D, 4'hF);
      do_write(LIMIT, 32'h1234_5678, 4'hF, 1, 0, b, ret, to);
      model_write(LIMIT, 32'h1234_5678, 4'hF);
      n_checks++;
      if (to || b !== {1'b1, exp_resp(LIMIT)} || !ret) begin
         n_fail++; $display("FAIL oor_write_resp: got to=%b b=%b ret=%b want b=110", to, b, ret);
      end
      do_read(LIMIT, r, to);
      n_checks++;
      if (to || r !== {1'b1, exp_resp(LIMIT), model_read(LIMIT)}) begin
         n_fail++; $display("FAIL oor_read: got %h want %h", r, {1'b1, exp_resp(LIMIT), model_read(LIMIT)});
      end
      do_read(32'h0, r, to);
      n_checks++;
      if (to || r !== {1'b1, 2'b00, model_read(32'h0)}) begin
         n_fail++; $display("FAIL oor_no_alias: got %h want %h", r, {1'b1, 2'b00, model_read(32'h0)});
      end
      do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, b, ret, to);
      model_write(32'h10, 32'hFFFF_FFFF, 4'h0);
      do_read(32'h10, r, to);
      n_checks++;
      if (to || b !== 3'b100 || r !== {1'b1, 2'b00, model_read(32'h10)}) begin
         n_fail++; $display("FAIL zero_strobe: got b=%b r=%h want b=100 r=%h", b, r, {1'b1, 2'b00, model_read(32'h10)});
      end
   endtask

   task automatic test_rready_hold;
      rready = 1'b0;
      araddr = 32'h10; arvalid = 1'b1;
      @(negedge clk);
      araddr = 32'h0;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if ({rvalid, rresp, rdata, arready} !== {1'b1, 2'b00, model_read(32'h10), 1'b0}) begin
            n_fail++; $display("FAIL r_hold%0d: got rv=%b rresp=%b rdata=%h arready=%b want 1 00 %h 0",
                               i, rvalid, rresp, rdata, arready, model_read(32'h10));
         end
         if (i < 5) @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({rvalid, arready} !== 2'b01) begin
         n_fail++; $display("FAIL r_release: got rvalid,arready=%b want 01", {rvalid, arready});
      end
      @(negedge clk);
      arvalid = 1'b0;
      n_checks++;
      if ({rvalid, rdata} !== {1'b1, model_read(32'h0)}) begin
         n_fail++; $display("FAIL r_second: got %b %h want 1 %h", rvalid, rdata, model_read(32'h0));
      end
      @(negedge clk);
   endtask

   task automatic test_collision;
      logic [2:0] b; logic ret; logic [34:0] r; bit to; word_t old_v;
      do_write(32'h20, 32'h1111_1111, 4'hF, 0, 0, b, ret, to);
      model_write(32'h20, 32'h1111_1111, 4'hF);
      old_v = model_read(32'h20);
      awaddr = 32'h20; awvalid = 1'b1;
      wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 32'h20; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model_write(32'h20, 32'h2222_2222, 4'hF);
      n_checks++;
      if ({bvalid, rvalid, rdata} !== {2'b11, old_v}) begin
         n_fail++; $display("FAIL collision_old: got bv=%b rv=%b rdata=%h want 1 1 %h", bvalid, rvalid, rdata, old_v);
      end
      @(negedge clk);
      do_read(32'h20, r, to);
      n_checks++;
      if (to || r !== {1'b1, 2'b00, model_read(32'h20)}) begin
         n_fail++; $display("FAIL collision_new: got %h want %h", r, {1'b1, 2'b00, model_read(32'h20)});
      end
   endtask

   task automatic test_back_to_back;
      int nb, nr;
      logic [34:0] r; bit to;
      nb = 0; nr = 0;
      awaddr = 32'h40; wdata = 32'hC0FF_EE00; wstrb = 4'hF; araddr = 32'h10;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bvalid) nb++;
         if (rvalid && rdata === model_read(32'h10)) nr++;
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model_write(32'h40, 32'hC0FF_EE00, 4'hF);
      repeat (2) @(negedge clk);
      n_checks++;
      if (nb !== 5 || nr !== 5) begin
         n_fail++; $display("FAIL b2b_rate: got b=%0d r=%0d want 5 5", nb, nr);
      end
      do_read(32'h40, r, to);
      n_checks++;
      if (to || r !== {1'b1, 2'b00, model_read(32'h40)}) begin
         n_fail++; $display("FAIL b2b_data: got %h want %h", r, {1'b1, 2'b00, model_read(32'h40)});
      end
   endtask

   task automatic test_random;
      logic [2:0] b; logic ret; logic [34:0] r; bit to;
      logic [31:0] a; word_t d; strb_t s; int sel;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         do_write(32'h100 + 32'(4 * i), d, 4'hF, 0, 0, b, ret, to);
         model_write(32'h100 + 32'(4 * i), d, 4'hF);
      end
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         a = (sel < 8) ? 32'h100 + 32'(4 * sel) + 32'($urandom_range(0, 3))
                       : ((sel == 8) ? LIMIT + 32'(4 * $urandom_range(0, 255)) : 32'hFFFF_FFFC);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), b, ret, to);
            n_checks++;
            if (to || b !== {1'b1, exp_resp(a)} || !ret) begin
               n_fail++; $display("FAIL rand_write%0d a=%h: got to=%b b=%b ret=%b want b=1%b", i, a, to, b, ret, exp_resp(a));
            end
            model_write(a, d, s);
         end else begin
            do_read(a, r, to);
            n_checks++;
            if (to || r !== {1'b1, exp_resp(a), model_read(a)}) begin
               n_fail++; $display("FAIL rand_read%0d a=%h: got %h want %h", i, a, r, {1'b1, exp_resp(a), model_read(a)});
            end
         end
      end
   endtask

   task automatic test_reset_midflight;
      logic [34:0] r; bit t1, t2, t3;
      bready = 1'b0; rready = 1'b0;
      fork
         send_aw(32'h30, 0, t1);
         send_w(32'h5A5A_5A5A, 4'hF, 0, t2);
      join
      model_write(32'h30, 32'h5A5A_5A5A, 4'hF);
      send_ar(32'h10, t3);
      n_checks++;
      if (t1 || t2 || t3 || {bvalid, rvalid} !== 2'b11) begin
         n_fail++; $display("FAIL midflight_setup: got bv=%b rv=%b to=%b%b%b want 11", bvalid, rvalid, t1, t2, t3);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bvalid, rvalid, awready, wready, arready, rdata} !== '0) begin
         n_fail++; $display("FAIL async_reset: got bv=%b rv=%b rdy=%b%b%b rdata=%h want all zero",
                            bvalid, rvalid, awready, wready, arready, rdata);
      end
      @(negedge clk);
      rst = 1'b0; bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
         n_fail++; $display("FAIL reset_recover: got %b want 11100", {awready, wready, arready, bvalid, rvalid});
      end
      do_read(32'h30, r, t1);
      n_checks++;
      if (t1 || r !== {1'b1, 2'b00, model_read(32'h30)}) begin
         n_fail++; $display("FAIL reset_retains: got %h want %h", r, {1'b1, 2'b00, model_read(32'h30)});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_w_before_aw();
      test_boundaries();
      test_rready_hold();
      test_collision();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
